// File: rtl/imm_gen_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : imm_gen_stage_if
// Description : Bundles the signals between the immediate-generator stage,
//               its upstream producer and its downstream consumer.
//               master = the environment around the stage (drives the input
//               side, consumes the output side); slave = the stage itself.
// Signals     : flush                        - discard held and incoming entries
//               in_valid/in_ready            - upstream handshake
//               in_instr[31:0], in_pc[XLEN]  - upstream payload
//               out_valid/out_ready          - downstream handshake
//               out_imm, out_fmt, out_target,
//               out_pc, out_instr            - downstream payload
// Revision    : 1.0 - initial release
// ============================================================================
interface imm_gen_stage_if #(
  parameter int XLEN = 32
) ();

  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_imm;
  logic [2:0]      out_fmt;
  logic [XLEN-1:0] out_target;
  logic [XLEN-1:0] out_pc;
  logic [31:0]     out_instr;

  modport master (
    output flush, in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_imm, out_fmt, out_target, out_pc, out_instr
  );

  modport slave (
    input  flush, in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_imm, out_fmt, out_target, out_pc, out_instr
  );

endinterface
`default_nettype wire

// File: rtl/imm_gen_stage.sv
`default_nettype none
// ============================================================================
// Module      : imm_gen_stage
// Description : RV32I immediate decoder as a one-cycle pipeline stage with a
//               two-entry (main + skid) output buffer. in_ready is driven
//               straight from a flop, so there is no combinational path from
//               out_ready to in_ready.
// Ports       : clk   - rising-edge clock
//               rst_n - asynchronous active-low reset
//               bus   - imm_gen_stage_if.slave (handshakes, payloads, flush)
// Parameters  : XLEN  - datapath width, 32 or 64
// Options     : IMMGEN_TARGET_EN - when defined, out_target carries the
//               registered pc + imm; otherwise out_target is tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module imm_gen_stage #(
  parameter int XLEN = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  imm_gen_stage_if.slave bus
);

  generate
    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
      $error("imm_gen_stage: XLEN must be 32 or 64");
    end
  endgenerate

  localparam logic [2:0] c_fmt_r   = 3'd0;
  localparam logic [2:0] c_fmt_i   = 3'd1;
  localparam logic [2:0] c_fmt_s   = 3'd2;
  localparam logic [2:0] c_fmt_b   = 3'd3;
  localparam logic [2:0] c_fmt_u   = 3'd4;
  localparam logic [2:0] c_fmt_j   = 3'd5;
  localparam logic [2:0] c_fmt_ill = 3'd7;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
`ifdef IMMGEN_TARGET_EN
    logic [XLEN-1:0] target;
`endif
  } entry_t;

  logic [31:0] w_ins;
  logic [31:0] w_imm32;
  logic [2:0]  w_fmt;
  entry_t      w_new;
  entry_t      r_main;
  entry_t      r_skid;
  logic        r_main_valid;
  logic        r_skid_valid;
  logic        w_acc;
  logic        w_pop;

  assign w_ins = bus.in_instr;

  // Decode: build a 32-bit immediate per format, then sign-extend from
  // instr[31] uniformly (U-type included, which matters at XLEN=64).
  always_comb begin
    w_imm32 = '0;
    w_fmt   = c_fmt_ill;
    case (w_ins[6:0])
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: begin
        w_fmt   = c_fmt_i;
        w_imm32 = {{20{w_ins[31]}}, w_ins[31:20]};
      end
      7'b0100011: begin
        w_fmt   = c_fmt_s;
        w_imm32 = {{20{w_ins[31]}}, w_ins[31:25], w_ins[11:7]};
      end
      7'b1100011: begin
        w_fmt   = c_fmt_b;
        w_imm32 = {{19{w_ins[31]}}, w_ins[31], w_ins[7], w_ins[30:25], w_ins[11:8], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        w_fmt   = c_fmt_u;
        w_imm32 = {w_ins[31:12], 12'b0};
      end
      7'b1101111: begin
        w_fmt   = c_fmt_j;
        w_imm32 = {{11{w_ins[31]}}, w_ins[31], w_ins[19:12], w_ins[20], w_ins[30:21], 1'b0};
      end
      7'b0110011: begin
        w_fmt   = c_fmt_r;
        w_imm32 = '0;
      end
      default: begin
        w_fmt   = c_fmt_ill;
        w_imm32 = '0;
      end
    endcase

    w_new       = '0;
    w_new.fmt   = w_fmt;
    w_new.pc    = bus.in_pc;
    w_new.instr = w_ins;
    // R and illegal leave w_imm32 at zero, but the upper bits still need
    // masking since they would otherwise copy instr[31].
    if (w_fmt != c_fmt_r && w_fmt != c_fmt_ill) begin
      w_new.imm        = {XLEN{w_ins[31]}};
      w_new.imm[31:0]  = w_imm32;
    end
`ifdef IMMGEN_TARGET_EN
    w_new.target = bus.in_pc + w_new.imm;
`endif
  end

  assign w_acc = bus.in_valid && !r_skid_valid;
  assign w_pop = r_main_valid && bus.out_ready;

  // While the skid entry is occupied in_ready is low, so no accept can
  // coincide with the skid-to-main move.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_main       <= '0;
      r_skid       <= '0;
    end else if (bus.flush) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (r_skid_valid) begin
      if (w_pop) begin
        r_main       <= r_skid;
        r_skid_valid <= 1'b0;
      end
    end else if (w_acc) begin
      if (!r_main_valid || bus.out_ready) begin
        r_main       <= w_new;
        r_main_valid <= 1'b1;
      end else begin
        r_skid       <= w_new;
        r_skid_valid <= 1'b1;
      end
    end else if (w_pop) begin
      r_main_valid <= 1'b0;
    end
  end

  assign bus.in_ready  = !r_skid_valid;
  assign bus.out_valid = r_main_valid;
  assign bus.out_imm   = r_main.imm;
  assign bus.out_fmt   = r_main.fmt;
  assign bus.out_pc    = r_main.pc;
  assign bus.out_instr = r_main.instr;
`ifdef IMMGEN_TARGET_EN
  assign bus.out_target = r_main.target;
`else
  assign bus.out_target = '0;
`endif

endmodule
`default_nettype wire

// File: doc/imm_gen_stage.md
IMM_GEN_STAGE -- requirements
Module: imm_gen_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath width; the block SHALL support exactly the values 32 and 64.
REQ-002 Port clk  input  1  clock; the block SHALL use only the rising edge.
REQ-003 Port rst_n  input  1  reset, asynchronous assert, active-low; the block SHALL have one clock and this reset only.
REQ-004 Port flush  input  1  SHALL discard all held and incoming entries.
REQ-005 Port in_valid  input  1  SHALL mark in_instr and in_pc as valid.
REQ-006 Port in_ready  output  1  SHALL indicate the stage can accept an entry.
REQ-007 Port in_instr  input  32  raw instruction word.
REQ-008 Port in_pc  input  XLEN  instruction address.
REQ-009 Port out_valid  output  1  SHALL mark the out_* data as valid.
REQ-010 Port out_ready  input  1  downstream accept.
REQ-011 Port out_imm  output  XLEN  sign-extended immediate.
REQ-012 Port out_fmt  output  3  format code: R=0, I=1, S=2, B=3, U=4, J=5, illegal=7.
REQ-013 Port out_target  output  XLEN  out_pc + out_imm (see Configuration).
REQ-014 Port out_pc, out_instr  output  XLEN, 32  pass-through of the accepted entry.

Function
REQ-015 Decode SHALL use opcode in_instr[6:0]: 0010011/0000011/1100111/1110011 give I; 0100011 gives S; 1100011 gives B; 0110111/0010111 give U; 1101111 gives J; 0110011 gives R.
REQ-016 Immediates SHALL follow RV32I bit layouts: I {[31:20]}; S {[31:25],[11:7]}; B {[31],[7],[30:25],[11:8],0}; U {[31:12],12'b0}; J {[31],[19:12],[20],[30:21],0}.
REQ-017 All formats, including U, SHALL sign-extend from in_instr[31] to XLEN bits.
REQ-018 Formats R and illegal SHALL give out_imm 0; any opcode not listed in REQ-015 SHALL give out_fmt 7.
REQ-019 A transfer SHALL occur on a rising edge with in_valid && in_ready; out_valid for that entry SHALL assert on the next edge (latency 1).
REQ-020 The block SHALL hold a main output register plus one skid entry (capacity 2).
REQ-021 in_ready SHALL equal !skid_valid, registered, with no combinational path from out_ready.
REQ-022 On accept: load the main register if it is empty or out_ready=1; otherwise load the skid entry.
REQ-023 On out_valid && out_ready with skid_valid=1, the skid entry SHALL move to main and skid_valid SHALL clear.
REQ-024 Entries SHALL leave the block in acceptance order; none SHALL be dropped or duplicated.
REQ-025 out_* data SHALL remain stable while out_valid=1 and out_ready=0.
REQ-026 flush=1 SHALL clear main and skid valid bits at the edge; an input accepted in the same cycle SHALL be discarded; flush SHALL take priority over accept.
REQ-027 Out_* data values under out_valid=0 are don't-care.

Reset
REQ-028 While rst_n=0: out_valid=0, skid_valid=0, in_ready=1, out_imm=0, out_fmt=0, out_target=0, out_pc=0, out_instr=0.
REQ-029 Reset asserted mid-transfer SHALL discard all entries immediately, without waiting for a clock edge.
REQ-030 The first accept SHALL be possible on the first rising edge after rst_n deasserts.

Configuration
REQ-031 Macro IMMGEN_TARGET_EN: when defined, out_target SHALL be the registered value (pc + imm) mod 2^XLEN for every format.
REQ-032 Without IMMGEN_TARGET_EN, out_target SHALL be tied to 0 and no adder SHALL be synthesised; all other behaviour SHALL be unchanged.

Verification
REQ-033 XLEN=32 I-type: in_instr 0xFFF00093 -> out_imm 0xFFFFFFFF, out_fmt 1 one cycle later.
REQ-034 S-type and U-type: 0xFE112E23 -> out_imm 0xFFFFFFFC, out_fmt 2; 0x123450B7 -> out_imm 0x12345000, out_fmt 4.
REQ-035 B-type with IMMGEN_TARGET_EN: 0xFE000CE3, in_pc 0x100 -> out_imm 0xFFFFFFF8, out_fmt 3, out_target 0x000000F8; at XLEN=64 -> out_imm 0xFFFFFFFFFFFFFFF8.
REQ-036 Backpressure: out_ready=0 with 3 back-to-back valid inputs -> A, B accepted, in_ready=0 on the third; raising out_ready delivers A, B, C in order with no loss.
REQ-037 Flush and reset: flush with 2 entries held plus a concurrent input -> out_valid=0 next cycle and nothing emitted; rst_n pulled low mid-stream -> out_valid=0 and in_ready=1 immediately.
